// File: rtl/seq_alu_pkg.sv
// ============================================================================
// seq_alu_pkg : shared opcodes, FSM state encoding and default word size
// Revision    : 1.0
// ============================================================================
`default_nettype none

package seq_alu_pkg;

  localparam int WORD_SIZE = 32;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu_core.sv
// ============================================================================
// alu_core : combinational single-cycle operations; shifts pass A (shamt 0)
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_core
  import seq_alu_pkg::*;
#(
  parameter int word_size = WORD_SIZE
) (
  input  logic [word_size-1:0] i_a,
  input  logic [word_size-1:0] i_b,
  input  logic [3:0]           i_op,
  output logic [word_size-1:0] o_result
);

  logic w_lt;
  assign w_lt = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_AND: o_result = i_a & i_b;
      OP_ADD: o_result = i_a + i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_SUB: o_result = i_a - i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_SLT: o_result = {{(word_size-1){1'b0}}, w_lt};
      // Only reached with a zero shift amount; longer shifts run in EXEC.
      OP_SLL, OP_SRL, OP_SRA: o_result = i_a;
      default: o_result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// seq_alu  : handshaked ALU with bit-serial shifts and shift-add multiply
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int word_size = WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [word_size-1:0] sourceA,
  input  logic [word_size-1:0] sourceB,
  input  logic [3:0]           ALUSel,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [word_size-1:0] output_data,
  output logic                 zero,
  output logic                 busy
);

  state_t               r_state;
  state_t               w_next_state;
  logic [word_size-1:0] r_a;
  logic [word_size-1:0] r_b;
  logic [word_size-1:0] r_acc;
  logic [word_size-1:0] r_out;
  logic [3:0]           r_op;
  logic [4:0]           r_sh_cnt;
  logic [5:0]           r_mul_cnt;

  logic [word_size-1:0] w_core_result;
  logic [word_size-1:0] w_shift_next;
  logic [word_size-1:0] w_acc_next;
  logic [4:0]           w_shamt;
  logic                 w_accept;
  logic                 w_go_exec;
  logic                 w_exec_last;
  logic                 w_r_is_mul;

  alu_core #(.word_size(word_size)) u_core (
    .i_a      (sourceA),
    .i_b      (sourceB),
    .i_op     (ALUSel),
    .o_result (w_core_result)
  );

  assign w_shamt     = sourceB[4:0];
  assign w_accept    = (r_state == ST_IDLE) && req_valid;
  assign w_go_exec   = (ALUSel == OP_MUL) || (is_shift(ALUSel) && (w_shamt != 5'd0));
  assign w_r_is_mul  = (r_op == OP_MUL);
  assign w_exec_last = w_r_is_mul ? (r_mul_cnt == 6'(word_size - 1)) : (r_sh_cnt == 5'd1);
  assign w_acc_next  = r_b[0] ? (r_acc + r_a) : r_acc;

  always_comb begin
    w_shift_next = r_a;
    case (r_op)
      OP_SLL:  w_shift_next = {r_a[word_size-2:0], 1'b0};
      OP_SRL:  w_shift_next = {1'b0, r_a[word_size-1:1]};
      OP_SRA:  w_shift_next = {r_a[word_size-1], r_a[word_size-1:1]};
      default: w_shift_next = r_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_next_state = w_go_exec ? ST_EXEC : ST_DONE;
      ST_EXEC: if (w_exec_last) w_next_state = ST_DONE;
      ST_DONE: if (resp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    resp_valid = (r_state == ST_DONE);
    busy       = (r_state != ST_IDLE);
  end

  // Multiply: r_a is the left-shifting multiplicand, r_b the right-shifting multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_out     <= '0;
      r_op      <= 4'd0;
      r_sh_cnt  <= 5'd0;
      r_mul_cnt <= 6'd0;
    end else if (w_accept) begin
      r_a       <= sourceA;
      r_b       <= sourceB;
      r_op      <= ALUSel;
      r_acc     <= '0;
      r_sh_cnt  <= w_shamt;
      r_mul_cnt <= 6'd0;
      if (!w_go_exec) r_out <= w_core_result;
    end else if (r_state == ST_EXEC) begin
      if (w_r_is_mul) begin
        r_acc     <= w_acc_next;
        r_a       <= {r_a[word_size-2:0], 1'b0};
        r_b       <= {1'b0, r_b[word_size-1:1]};
        r_mul_cnt <= r_mul_cnt + 6'd1;
        if (w_exec_last) r_out <= w_acc_next;
      end else begin
        r_a      <= w_shift_next;
        r_sh_cnt <= r_sh_cnt - 5'd1;
        if (w_exec_last) r_out <= w_shift_next;
      end
    end
  end

  assign output_data = r_out;
  assign zero        = (r_out == '0);

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// tb_seq_alu : table-driven self-checking bench for seq_alu
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_seq_alu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] sourceA;
  logic [31:0] sourceB;
  logic [3:0]  ALUSel;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] output_data;
  logic        zero;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  seq_alu #(.word_size(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .sourceA     (sourceA),
    .sourceB     (sourceB),
    .ALUSel      (ALUSel),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .output_data (output_data),
    .zero        (zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one request for a single cycle, then scramble the inputs.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req_valid = 1'b1;
    sourceA   = a;
    sourceB   = b;
    ALUSel    = op;
    tick();
    req_valid = 1'b0;
    sourceA   = 32'hDEAD_BEEF;
    sourceB   = 32'h0000_0003;
    ALUSel    = 4'd1;
  endtask

  // Returns k such that resp_valid first appears in cycle N+k; flags busy dropouts.
  task automatic wait_resp(output int lat, output logic busy_bad);
    lat      = 1;
    busy_bad = 1'b0;
    while (!resp_valid && lat < 60) begin
      if (!busy) busy_bad = 1'b1;
      tick();
      lat++;
    end
    if (!busy) busy_bad = 1'b1;
  endtask

  initial begin
    int          lat;
    logic        bb;
    logic [31:0] r;

    vecs[0]  = '{32'd4,         32'd5,         4'd1,  32'd9,          1};
    vecs[1]  = '{32'd5,         32'd5,         4'd3,  32'd0,          1};
    vecs[2]  = '{32'hFFFFFFFF,  32'd1,         4'd5,  32'd1,          1};
    vecs[3]  = '{32'd1,         32'hFFFFFFFF,  4'd5,  32'd0,          1};
    vecs[4]  = '{32'h1234_5678, 32'd9,         4'd12, 32'd0,          1};
    vecs[5]  = '{32'hF0F0_FF00, 32'h0FF0_F0F0, 4'd0,  32'h00F0_F000,  1};
    vecs[6]  = '{32'hF000_000F, 32'h0F00_00F0, 4'd2,  32'hFF00_00FF,  1};
    vecs[7]  = '{32'hAAAA_5555, 32'hFFFF_0000, 4'd4,  32'h5555_5555,  1};
    vecs[8]  = '{32'h8000_0000, 32'd4,         4'd7,  32'h0800_0000,  5};
    vecs[9]  = '{32'h1357_9BDF, 32'h0000_0020, 4'd6,  32'h1357_9BDF,  1};
    vecs[10] = '{32'h8000_0000, 32'd31,        4'd8,  32'hFFFF_FFFF,  32};
    vecs[11] = '{32'd12,        32'd10,        4'd9,  32'd120,        33};
    vecs[12] = '{32'hFFFF_FFFF, 32'd2,         4'd9,  32'hFFFF_FFFE,  33};
    vecs[13] = '{32'd3,         32'd7,         4'd3,  32'hFFFF_FFFC,  1};

    rst        = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    sourceA    = '0;
    sourceB    = '0;
    ALUSel     = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("reset_data",       output_data, 32'd0);
    chk("reset_zero",       {31'd0, zero}, 32'd1);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_busy",       {31'd0, busy}, 32'd0);
    chk("reset_req_ready",  {31'd0, req_ready}, 32'd1);

    // ADD with resp_ready already high: response lives for exactly one cycle.
    resp_ready = 1'b1;
    issue(32'd4, 32'd5, 4'd1);
    chk("add_n1_valid", {31'd0, resp_valid}, 32'd1);
    chk("add_n1_data",  output_data, 32'd9);
    chk("add_n1_zero",  {31'd0, zero}, 32'd0);
    chk("add_n1_ready", {31'd0, req_ready}, 32'd0);
    tick();
    chk("add_n2_valid", {31'd0, resp_valid}, 32'd0);
    chk("add_n2_ready", {31'd0, req_ready}, 32'd1);
    resp_ready = 1'b0;

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].op);
      wait_resp(lat, bb);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_data", i), output_data, vecs[i].exp);
      chk($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].exp == 32'd0});
      chk($sformatf("vec%0d_busy", i), {31'd0, bb}, 32'd0);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk($sformatf("vec%0d_release", i), {30'd0, resp_valid, req_ready}, 32'd1);
    end

    // SLL 1 by 4, held unacknowledged for 3 cycles.
    issue(32'd1, 32'd4, 4'd6);
    wait_resp(lat, bb);
    chk("sll_hold_latency", 32'(lat), 32'd5);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("sll_hold_data%0d", c), output_data, 32'd16);
      chk($sformatf("sll_hold_valid%0d", c), {31'd0, resp_valid}, 32'd1);
      tick();
    end
    chk("sll_hold_data3", output_data, 32'd16);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("sll_hold_release", {30'd0, resp_valid, req_ready}, 32'd1);

    // Reset during the 10th EXEC cycle of a multiply.
    issue(32'd12, 32'd10, 4'd9);
    for (int c = 1; c < 10; c++) tick();
    chk("mul_abort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mul_abort_valid", {31'd0, resp_valid}, 32'd0);
    chk("mul_abort_ready", {31'd0, req_ready}, 32'd1);
    chk("mul_abort_data",  output_data, 32'd0);
    r = 32'd0;
    for (int c = 0; c < 40; c++) begin
      if (resp_valid) r = 32'd1;
      tick();
    end
    chk("mul_abort_no_resp", r, 32'd0);
    issue(32'd8, 32'd6, 4'd1);
    chk("post_abort_valid", {31'd0, resp_valid}, 32'd1);
    chk("post_abort_data",  output_data, 32'd14);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Reset wins over a simultaneous request.
    rst       = 1'b1;
    req_valid = 1'b1;
    sourceA   = 32'd1;
    sourceB   = 32'd1;
    ALUSel    = 4'd1;
    tick();
    rst       = 1'b0;
    req_valid = 1'b0;
    chk("rst_prio_busy",  {31'd0, busy}, 32'd0);
    chk("rst_prio_valid", {31'd0, resp_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
